// File: rtl/egress_rr_scheduler_if.sv
// Queue-side and link-side signals of the egress scheduler.
// The master modport is the scheduler; the slave modport is the queues plus the downstream link.
interface egress_rr_scheduler_if #(
    parameter int unsigned NUM_PORTS = 4,
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned PORT_W    = $clog2(NUM_PORTS)
);
    logic [NUM_PORTS-1:0]       q_empty;
    logic [NUM_PORTS*WIDTH-1:0] q_data;
    logic [NUM_PORTS-1:0]       q_dequeue;
    logic                       out_valid;
    logic                       out_ready;
    logic [WIDTH-1:0]           out_data;
    logic [PORT_W-1:0]          out_port;

    modport master (
        input  q_empty,
        input  q_data,
        input  out_ready,
        output q_dequeue,
        output out_valid,
        output out_data,
        output out_port
    );

    modport slave (
        output q_empty,
        output q_data,
        output out_ready,
        input  q_dequeue,
        input  out_valid,
        input  out_data,
        input  out_port
    );
endinterface

// File: rtl/egress_rr_scheduler.sv
// Round-robin egress scheduler with a per-grant burst limit; one queue pop in flight at a time.
// Pop, capture and hand-off run as a 4-state loop: IDLE -> POP -> CAPT -> HOLD.
module egress_rr_scheduler #(
    parameter int unsigned NUM_PORTS = 4,
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned BURST     = 4,
    parameter int unsigned PORT_W    = $clog2(NUM_PORTS)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   enable,
    egress_rr_scheduler_if.master  bus,
    output logic                   busy
);

    typedef enum logic [1:0] {
        StIdle,
        StPop,
        StCapt,
        StHold
    } state_e;

    localparam logic [PORT_W-1:0] LastPort = PORT_W'(NUM_PORTS - 1);
    localparam logic [3:0]        BurstMax = 4'(BURST);

    state_e            state_q;
    logic [PORT_W-1:0] grant_q;
    logic [3:0]        burst_cnt_q;
    logic              out_valid_q;
    logic [WIDTH-1:0]  out_data_q;
    logic [PORT_W-1:0] out_port_q;

    logic              any_req;
    logic              burst_cont;
    logic              hi_hit;
    logic              lo_hit;
    logic [PORT_W-1:0] hi_sel;
    logic [PORT_W-1:0] lo_sel;
    logic [PORT_W-1:0] scan_sel;

    assign any_req = |(~bus.q_empty);

    // burst_cnt == 0 only right after reset: no burst is active yet, so the search starts at port 0.
    assign burst_cont = !bus.q_empty[grant_q] && (burst_cnt_q != 4'd0) &&
                        (burst_cnt_q < BurstMax);

    // Rotating search: lowest non-empty port above grant wins, else wrap to lowest at/below grant.
    always_comb begin
        hi_hit = 1'b0;
        lo_hit = 1'b0;
        hi_sel = '0;
        lo_sel = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (!bus.q_empty[i]) begin
                if (i > int'(grant_q)) begin
                    hi_hit = 1'b1;
                    hi_sel = PORT_W'(i);
                end else begin
                    lo_hit = 1'b1;
                    lo_sel = PORT_W'(i);
                end
            end
        end
        scan_sel = hi_hit ? hi_sel : lo_sel;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            grant_q     <= LastPort;
            burst_cnt_q <= 4'd0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_port_q  <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (enable && any_req) begin
                        if (burst_cont) begin
                            burst_cnt_q <= burst_cnt_q + 4'd1;
                        end else begin
                            // Covers the lone-queue case too: the scan wraps back and restarts at 1.
                            grant_q     <= scan_sel;
                            burst_cnt_q <= 4'd1;
                        end
                        state_q <= StPop;
                    end
                end
                StPop: begin
                    state_q <= StCapt;
                end
                StCapt: begin
                    out_data_q  <= bus.q_data[grant_q*WIDTH +: WIDTH];
                    out_port_q  <= grant_q;
                    out_valid_q <= 1'b1;
                    state_q     <= StHold;
                end
                StHold: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    always_comb begin
        bus.q_dequeue = '0;
        if (state_q == StPop) begin
            bus.q_dequeue[grant_q] = 1'b1;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_port  = out_port_q;
    assign busy          = (state_q != StIdle);

    // lo_hit is implied by any_req whenever hi_hit is clear; kept only for readability of the scan.
    logic unused_lo_hit;
    assign unused_lo_hit = lo_hit;

endmodule

// File: tb/tb_egress_rr_scheduler.sv
// Directed bench for egress_rr_scheduler: queue models with 1-cycle pop latency and an
// acceptance log, checked against hand-computed port/data sequences.
module tb_egress_rr_scheduler;

    localparam int NP = 4;
    localparam int W  = 8;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic enable = 1'b0;
    logic out_ready = 1'b0;
    logic busy;

    egress_rr_scheduler_if #(.NUM_PORTS(NP), .WIDTH(W)) bus ();

    egress_rr_scheduler #(
        .NUM_PORTS(NP),
        .WIDTH    (W),
        .BURST    (4)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .enable (enable),
        .bus    (bus),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    // Queue models: wr_ptr owned by the stimulus, rd_ptr by the pop process.
    logic [7:0]    mem [NP][32];
    int            wr_ptr [NP];
    int            rd_ptr [NP];
    logic [NP*W-1:0] q_data_r = '0;

    assign bus.q_data    = q_data_r;
    assign bus.out_ready = out_ready;

    always_comb begin
        for (int p = 0; p < NP; p++) bus.q_empty[p] = (wr_ptr[p] == rd_ptr[p]);
    end

    always @(posedge clk) begin
        for (int p = 0; p < NP; p++) begin
            if (bus.q_dequeue[p] && rd_ptr[p] != wr_ptr[p]) begin
                q_data_r[p*W +: W] <= mem[p][rd_ptr[p] % 32];
                rd_ptr[p] <= rd_ptr[p] + 1;
            end
        end
    end

    typedef struct {
        int port;
        int data;
        int cyc;
    } acc_t;

    acc_t acc_q[$];
    int   cyc_n  = 0;
    int   dq_bad = 0;

    always @(posedge clk) begin
        cyc_n <= cyc_n + 1;
        if (reset_n && !$onehot0(bus.q_dequeue)) dq_bad <= dq_bad + 1;
        if (reset_n && bus.out_valid && bus.out_ready)
            acc_q.push_back('{port: int'(bus.out_port), data: int'(bus.out_data), cyc: cyc_n});
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input int p, input logic [7:0] d);
        mem[p][wr_ptr[p] % 32] = d;
        wr_ptr[p] = wr_ptr[p] + 1;
    endtask

    task automatic wait_acc(input string tag, input int target, input int budget);
        int t = 0;
        while (acc_q.size() < target && t < budget) begin
            cyc(1);
            t++;
        end
        if (acc_q.size() < target) check(tag, acc_q.size(), target);
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int t = 0;
        while (!bus.out_valid && t < budget) begin
            cyc(1);
            t++;
        end
        if (!bus.out_valid) check(tag, 0, 1);
    endtask

    task automatic check_acc(input string tag, input int idx, input int port, input int data);
        if (idx < acc_q.size())
            check(tag, {acc_q[idx].port[7:0], acc_q[idx].data[7:0]}, {port[7:0], data[7:0]});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int exp_t2 [24] = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2, 3, 3, 3, 3, 0, 0, 1, 1, 2, 2, 3, 3};
        int nk [NP];

        // Reset state
        out_ready = 1'b1;
        cyc(3);
        check("rst_valid", bus.out_valid, 0);
        check("rst_data",  bus.out_data, 0);
        check("rst_port",  bus.out_port, 0);
        check("rst_deq",   bus.q_dequeue, 0);
        check("rst_busy",  busy, 0);

        // Single word from queue 2: pop, capture, present, accept
        push(2, 8'hA5);
        enable  = 1'b1;
        reset_n = 1'b1;
        cyc(1);
        check("t1_deq", bus.q_dequeue, 4'b0100);
        check("t1_busy", busy, 1);
        cyc(1);
        check("t1_deq_off", {bus.q_dequeue, bus.out_valid}, 0);
        cyc(1);
        check("t1_out", {bus.out_valid, bus.out_data, bus.out_port}, {1'b1, 8'hA5, 2'd2});
        cyc(1);
        check("t1_idle", {busy, bus.out_valid}, 0);
        cyc(3);
        check("t1_quiet", {busy, bus.q_dequeue}, 0);

        // All queues loaded, burst limit 4, fresh reset
        reset_n = 1'b0;
        for (int p = 0; p < NP; p++) begin
            for (int k = 0; k < 6; k++) push(p, 8'(p * 16 + k));
            nk[p] = 0;
        end
        cyc(1);
        reset_n = 1'b1;
        base = acc_q.size();
        wait_acc("t2_timeout", base + 24, 200);
        for (int j = 0; j < 24; j++) begin
            check_acc("t2_word", base + j, exp_t2[j], exp_t2[j] * 16 + nk[exp_t2[j]]);
            nk[exp_t2[j]]++;
        end
        check("t2_onehot", dq_bad, 0);

        // Lone queue 1: served continuously across burst boundaries, one word per 4 cycles
        base = acc_q.size();
        for (int k = 0; k < 10; k++) push(1, 8'(8'h80 + k));
        wait_acc("t3_timeout", base + 10, 100);
        for (int j = 0; j < 10; j++) begin
            check_acc("t3_word", base + j, 1, 8'h80 + j);
            if (j > 0 && base + j < acc_q.size())
                check("t3_gap", acc_q[base + j].cyc - acc_q[base + j - 1].cyc, 4);
        end

        // Backpressure in HOLD
        out_ready = 1'b0;
        push(0, 8'h3C);
        wait_valid("t4_valid_timeout", 20);
        check("t4_port", bus.out_port, 0);
        for (int i = 0; i < 20; i++) begin
            check("t4_hold", {bus.out_valid, bus.out_data, bus.q_dequeue}, {1'b1, 8'h3C, 4'b0});
            cyc(1);
        end
        push(0, 8'h3D);
        base = acc_q.size();
        out_ready = 1'b1;
        cyc(1);
        check("t4_release", {bus.out_valid, busy}, 0);
        check("t4_once", acc_q.size(), base + 1);
        check_acc("t4_word", base, 0, 8'h3C);
        cyc(1);
        check("t4_next_pop", bus.q_dequeue, 4'b0001);
        wait_acc("t4_timeout", base + 2, 20);
        check_acc("t4_word2", base + 1, 0, 8'h3D);

        // Drop enable during CAPT; word completes, then idle; resume from saved grant/burst
        base = acc_q.size();
        push(0, 8'h50);
        push(0, 8'h51);
        push(2, 8'h70);
        cyc(1);
        check("t5_deq", bus.q_dequeue, 4'b0001);
        cyc(1);
        enable = 1'b0;
        cyc(1);
        check("t5_out", {bus.out_valid, bus.out_data}, {1'b1, 8'h50});
        cyc(1);
        for (int i = 0; i < 8; i++) begin
            check("t5_idle", {busy, bus.q_dequeue}, 0);
            cyc(1);
        end
        check("t5_count", acc_q.size(), base + 1);
        enable = 1'b1;
        wait_acc("t5_timeout", base + 3, 30);
        check_acc("t5_w1", base + 1, 0, 8'h51);
        check_acc("t5_w2", base + 2, 2, 8'h70);

        // Reset during HOLD discards the word; restart from lowest-index non-empty queue
        base = acc_q.size();
        out_ready = 1'b0;
        push(3, 8'h33);
        push(3, 8'h34);
        push(1, 8'h11);
        wait_valid("t6_valid_timeout", 20);
        check("t6_hold", {bus.out_port, bus.out_data}, {2'd3, 8'h33});
        reset_n = 1'b0;
        cyc(1);
        check("t6_rst_valid", bus.out_valid, 0);
        check("t6_rst_data", bus.out_data, 0);
        check("t6_rst_busy", busy, 0);
        reset_n   = 1'b1;
        out_ready = 1'b1;
        wait_acc("t6_timeout", base + 2, 30);
        check_acc("t6_w0", base, 1, 8'h11);
        check_acc("t6_w1", base + 1, 3, 8'h34);
        cyc(8);
        check("t6_count", acc_q.size(), base + 2);
        check("final_onehot", dq_bad, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
